// File: rtl/display_page_sequencer.sv
// Page sequencer feeding the 7-segment display interface: freezable 64-bit snapshot,
// debounced "next page" key and optional auto-scroll timer driving a 2-bit page select.
module display_page_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SCROLL_CYCLES   = 50000000,
    parameter int unsigned DATA_WIDTH      = 64
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic [DATA_WIDTH-1:0] iData,
    input  logic                  iKeyNext,
    input  logic                  iAutoScroll,
    input  logic                  iFreeze,
    output logic [DATA_WIDTH-1:0] oOutput,
    output logic [1:0]            oSelect,
    output logic                  oPressPulse
);

    localparam int unsigned CntWidth    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned ScrollWidth = $clog2(SCROLL_CYCLES);

    localparam logic [CntWidth-1:0]    DebLast    = CntWidth'(DEBOUNCE_CYCLES - 1);
    localparam logic [ScrollWidth-1:0] ScrollLast = ScrollWidth'(SCROLL_CYCLES - 1);

    typedef enum logic [1:0] {
        StUp,
        StWaitDown,
        StDown,
        StWaitUp
    } debState_e;

    logic                   keyMeta;
    logic                   kSync;
    debState_e              debState;
    logic [CntWidth-1:0]    debCnt;
    logic [CntWidth-1:0]    debCntInc;
    logic                   debDone;
    logic [ScrollWidth-1:0] scrollCnt;
    logic                   scrollExpire;
    logic                   advance;

    // Key is active-low, so the synchronizer resets to the released level.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            keyMeta <= 1'b1;
            kSync   <= 1'b1;
        end else begin
            keyMeta <= iKeyNext;
            kSync   <= keyMeta;
        end
    end

    // Entry into a wait state is the first stable sample, so the level is accepted
    // once the count reaches DEBOUNCE_CYCLES-1 (DEBOUNCE_CYCLES stable samples in all).
    assign debCntInc = debCnt + CntWidth'(1);
    assign debDone   = (debCntInc >= DebLast);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            debState    <= StUp;
            debCnt      <= '0;
            oPressPulse <= 1'b0;
        end else begin
            oPressPulse <= 1'b0;
            case (debState)
                StUp: begin
                    if (!kSync) begin
                        debState <= StWaitDown;
                        debCnt   <= '0;
                    end
                end
                StWaitDown: begin
                    if (kSync) begin
                        debState <= StUp;
                    end else if (debDone) begin
                        debState    <= StDown;
                        debCnt      <= debCntInc;
                        oPressPulse <= 1'b1;
                    end else begin
                        debCnt <= debCntInc;
                    end
                end
                StDown: begin
                    if (kSync) begin
                        debState <= StWaitUp;
                        debCnt   <= '0;
                    end
                end
                StWaitUp: begin
                    if (!kSync) begin
                        debState <= StDown;
                    end else if (debDone) begin
                        debState <= StUp;
                        debCnt   <= debCntInc;
                    end else begin
                        debCnt <= debCntInc;
                    end
                end
                default: debState <= StUp;
            endcase
        end
    end

    assign scrollExpire = iAutoScroll && (scrollCnt == ScrollLast);
    // A press and an expiry landing together still advance the page only once.
    assign advance      = oPressPulse || scrollExpire;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            scrollCnt <= '0;
            oSelect   <= 2'b00;
        end else begin
            if (!iAutoScroll || advance) begin
                scrollCnt <= '0;
            end else begin
                scrollCnt <= scrollCnt + ScrollWidth'(1);
            end
            if (advance) begin
                oSelect <= oSelect + 2'd1;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oOutput <= '0;
        end else if (!iFreeze) begin
            oOutput <= iData;
        end
    end

endmodule

// File: tb/tb_display_page_sequencer.sv
// Directed bench for display_page_sequencer with short debounce (4) and scroll (10) periods.
module tb_display_page_sequencer;

    localparam int unsigned Deb = 4;
    localparam int unsigned Scr = 10;

    logic        clk;
    logic        rst;
    logic [63:0] data;
    logic        key;
    logic        autoScroll;
    logic        freeze;
    logic [63:0] outVal;
    logic [1:0]  sel;
    logic        pulse;

    int nChecks;
    int nFails;

    localparam logic [63:0] ValInit = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] ValA    = 64'hAAAA_5555_1234_5678;
    localparam logic [63:0] ValB    = 64'h0F0F_F0F0_CAFE_BABE;

    display_page_sequencer #(
        .DEBOUNCE_CYCLES(Deb),
        .SCROLL_CYCLES  (Scr),
        .DATA_WIDTH     (64)
    ) dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iData      (data),
        .iKeyNext   (key),
        .iAutoScroll(autoScroll),
        .iFreeze    (freeze),
        .oOutput    (outVal),
        .oSelect    (sel),
        .oPressPulse(pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press();
        key = 1'b0;
        repeat (8) tick();
        key = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        nChecks    = 0;
        nFails     = 0;
        rst        = 1'b1;
        key        = 1'b1;
        data       = 64'hFFFF_0000_DEAD_BEEF;
        autoScroll = 1'b1;
        freeze     = 1'b0;

        // Reset with arbitrary inputs
        repeat (3) tick();
        check("rst out", outVal, 64'd0);
        check("rst sel", {62'd0, sel}, 64'd0);
        check("rst pulse", {63'd0, pulse}, 64'd0);
        autoScroll = 1'b0;
        data       = ValInit;
        tick();
        rst = 1'b0;
        check("release out before edge", outVal, 64'd0);
        tick();
        check("out follows data", outVal, ValInit);

        // Clean press held for 20 cycles: single pulse 6 edges after the press
        key = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("clean pulse %0d", i), {63'd0, pulse}, {63'd0, (i == 6)});
            check($sformatf("clean sel %0d", i), {62'd0, sel}, (i >= 7) ? 64'd1 : 64'd0);
        end
        key = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("release pulse %0d", i), {63'd0, pulse}, 64'd0);
        end
        check("after release sel", {62'd0, sel}, 64'd1);

        // Bounce: 2-cycle low/high toggling never debounces
        for (int i = 0; i < 12; i++) begin
            key = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("bounce pulse %0d", i), {63'd0, pulse}, 64'd0);
        end
        key = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("bounce tail pulse %0d", i), {63'd0, pulse}, 64'd0);
        end
        check("bounce sel", {62'd0, sel}, 64'd1);

        // Wrap through all pages
        press();
        check("wrap sel 2", {62'd0, sel}, 64'd2);
        press();
        check("wrap sel 3", {62'd0, sel}, 64'd3);
        press();
        check("wrap sel 0", {62'd0, sel}, 64'd0);
        press();
        check("wrap sel 1", {62'd0, sel}, 64'd1);

        // Auto-scroll every 10 cycles
        autoScroll = 1'b1;
        repeat (9) tick();
        check("auto sel before 1st", {62'd0, sel}, 64'd1);
        tick();
        check("auto sel 1st", {62'd0, sel}, 64'd2);
        repeat (9) tick();
        check("auto sel before 2nd", {62'd0, sel}, 64'd2);
        tick();
        check("auto sel 2nd", {62'd0, sel}, 64'd3);

        // Press pulse lands on the cycle of the third expiry
        repeat (3) tick();
        key = 1'b0;
        repeat (6) tick();
        check("collide pulse", {63'd0, pulse}, 64'd1);
        check("collide sel before", {62'd0, sel}, 64'd3);
        tick();
        check("collide single advance", {62'd0, sel}, 64'd0);
        check("collide pulse off", {63'd0, pulse}, 64'd0);
        key = 1'b1;
        repeat (9) tick();
        check("post collide sel hold", {62'd0, sel}, 64'd0);
        tick();
        check("post collide advance", {62'd0, sel}, 64'd1);

        // Press mid-period restarts the scroll timer
        tick();
        key = 1'b0;
        repeat (7) tick();
        check("midperiod press sel", {62'd0, sel}, 64'd2);
        key = 1'b1;
        repeat (2) tick();
        check("timer cleared by press", {62'd0, sel}, 64'd2);
        repeat (7) tick();
        check("full period hold", {62'd0, sel}, 64'd2);
        tick();
        check("full period advance", {62'd0, sel}, 64'd3);
        autoScroll = 1'b0;

        // Freeze holds the last unfrozen sample across page changes
        data = ValA;
        tick();
        check("freeze pre A", outVal, ValA);
        freeze = 1'b1;
        data   = ValB;
        tick();
        check("frozen A", outVal, ValA);
        press();
        check("frozen A after press", outVal, ValA);
        check("frozen sel wrap", {62'd0, sel}, 64'd0);
        freeze = 1'b0;
        check("unfreeze before edge", outVal, ValA);
        tick();
        check("unfrozen B", outVal, ValB);

        // Reset during WAIT_DOWN, key still held afterwards
        key = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("midrst sel", {62'd0, sel}, 64'd0);
        check("midrst pulse", {63'd0, pulse}, 64'd0);
        check("midrst out", outVal, 64'd0);
        repeat (2) tick();
        check("midrst held pulse", {63'd0, pulse}, 64'd0);
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("fresh pulse %0d", i), {63'd0, pulse}, {63'd0, (i == 6)});
            check($sformatf("fresh sel %0d", i), {62'd0, sel}, (i == 7) ? 64'd1 : 64'd0);
        end
        key = 1'b1;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
